// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a programmable target pattern.
// The detector is armed by pat_load, fills PAT_W bits of history, then compares
// each new history word against the stored pattern. Overlapping or
// non-overlapping detection is chosen per cycle. Matches are counted in a
// saturating counter.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat,
    output logic             armed
);

    // The fill counter must be able to hold the value PAT_W.
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sample;
    logic               full_now;
    logic               hit;

    // Datapath decode: the history word that would result from this cycle's
    // sample, and whether that sample completes a valid comparison.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], din};
        sample     = ena && (state_q != UNARMED);
        // A full window exists either in RUN, or in FILL when this sample is
        // the PAT_W-th valid bit.
        full_now   = (state_q == RUN) ||
                     ((state_q == FILL) && (fill_q == FILL_LAST));
        // pat_load wins over a same-cycle sample, so it also suppresses a hit.
        hit        = sample && full_now && !pat_load && (hist_shift == pat_q);
    end

    // Next-state logic for the FSM, history, fill count and match pulse.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;

        if (pat_load) begin
            // Re-arm: new pattern, empty history; the concurrent sample is dropped.
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (sample) begin
            hist_d = hist_shift;
            if (state_q == FILL) begin
                if (fill_q == FILL_LAST) begin
                    fill_d  = FILL_FULL;
                    state_d = RUN;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping mode: no bit of this match may be reused.
                if (!overlap) begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end
    end

    // Saturating match counter; a clear beats a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNARMED;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        match       = match_q;
        match_count = cnt_q;
        cnt_sat     = &cnt_q;
        armed       = (state_q != UNARMED);
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param (PAT_W=4, CNT_W=2).
// Expected match bits are queued as each cycle is driven and popped when the
// registered match output is sampled on the following falling edge.
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             din;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             clr_cnt;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             cnt_sat;
    logic             armed;

    int    n_pass  = 0;
    int    n_total = 0;
    string cur     = "init";
    logic  sb_q[$];

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt), .match(match),
        .match_count(match_count), .cnt_sat(cnt_sat), .armed(armed)
    );

    always #5 clk = ~clk;

    // One clock: queue the expected match, let the edge happen, then pop and
    // compare the registered pulse on the falling edge.
    task automatic tick(input logic exp_match);
        logic e;
        sb_q.push_back(exp_match);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        n_total++;
        if (match !== e) $display("FAIL %s match: got %b want %b", cur, match, e);
        else n_pass++;
    endtask

    // Drive n serial bits MSB first with ena=1; exps holds the per-bit match expectation.
    task automatic send_bits(input logic [15:0] bits, input int n, input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) begin
            ena = 1'b1;
            din = bits[i];
            tick(exps[i]);
        end
        ena = 1'b0;
        din = 1'b0;
    endtask

    // Arm with a new pattern and clear the counter in the same cycle.
    task automatic load(input logic [PAT_W-1:0] p);
        pat_load = 1'b1;
        pat_in   = p;
        clr_cnt  = 1'b1;
        ena      = 1'b0;
        tick(1'b0);
        pat_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        n_total++; if (match_count !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", match_count); else n_pass++;
        n_total++; if (cnt_sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", cnt_sat); else n_pass++;
        n_total++; if (armed !== 1'b0) $display("FAIL reset_armed: got %b want 0", armed); else n_pass++;
        rst = 1'b0;
        cur = "unarmed";
        send_bits(16'b0000, 4, 16'b0000);
        send_bits(16'b1011, 4, 16'b0000);
        n_total++; if (armed !== 1'b0) $display("FAIL unarmed_armed: got %b want 0", armed); else n_pass++;
        n_total++; if (match_count !== 2'd0) $display("FAIL unarmed_cnt: got %0d want 0", match_count); else n_pass++;
    endtask

    task automatic test_overlap();
        cur = "overlap";
        overlap = 1'b1;
        load(4'b1011);
        n_total++; if (armed !== 1'b1) $display("FAIL ovl_armed: got %b want 1", armed); else n_pass++;
        send_bits(16'b1011011, 7, 16'b0001001);
        n_total++; if (match_count !== 2'd2) $display("FAIL ovl_cnt: got %0d want 2", match_count); else n_pass++;
    endtask

    task automatic test_non_overlap();
        cur = "nonovl_a";
        overlap = 1'b0;
        load(4'b1011);
        send_bits(16'b1011011, 7, 16'b0001000);
        n_total++; if (match_count !== 2'd1) $display("FAIL novl_cnt_a: got %0d want 1", match_count); else n_pass++;
        n_total++; if (armed !== 1'b1) $display("FAIL novl_armed: got %b want 1", armed); else n_pass++;
        cur = "nonovl_b";
        load(4'b1011);
        send_bits(16'b10111011, 8, 16'b00010001);
        n_total++; if (match_count !== 2'd2) $display("FAIL novl_cnt_b: got %0d want 2", match_count); else n_pass++;
    endtask

    task automatic test_saturate();
        cur = "saturate";
        overlap = 1'b1;
        load(4'b1011);
        send_bits(16'b1011011011011011, 16, 16'b0001001001001001);
        n_total++; if (match_count !== 2'd3) $display("FAIL sat_cnt: got %0d want 3", match_count); else n_pass++;
        n_total++; if (cnt_sat !== 1'b1) $display("FAIL sat_flag: got %b want 1", cnt_sat); else n_pass++;
        clr_cnt = 1'b1;
        tick(1'b0);
        clr_cnt = 1'b0;
        n_total++; if (match_count !== 2'd0) $display("FAIL clr_cnt: got %0d want 0", match_count); else n_pass++;
        n_total++; if (cnt_sat !== 1'b0) $display("FAIL clr_sat: got %b want 0", cnt_sat); else n_pass++;
    endtask

    task automatic test_clr_priority();
        cur = "clr_prio";
        overlap = 1'b1;
        load(4'b1011);
        send_bits(16'b1011, 4, 16'b0001);
        n_total++; if (match_count !== 2'd1) $display("FAIL prio_pre_cnt: got %0d want 1", match_count); else n_pass++;
        send_bits(16'b01, 2, 16'b00);
        ena = 1'b1; din = 1'b1; clr_cnt = 1'b1;
        tick(1'b1);
        ena = 1'b0; clr_cnt = 1'b0;
        n_total++; if (match_count !== 2'd0) $display("FAIL prio_cnt: got %0d want 0", match_count); else n_pass++;
    endtask

    task automatic test_ena_gap();
        cur = "ena_gap";
        overlap = 1'b1;
        load(4'b1011);
        send_bits(16'b101, 3, 16'b000);
        for (int i = 0; i < 3; i++) begin
            ena = 1'b0; din = 1'b1;
            tick(1'b0);
        end
        n_total++; if (armed !== 1'b1) $display("FAIL gap_armed: got %b want 1", armed); else n_pass++;
        send_bits(16'b1, 1, 16'b1);
        tick(1'b0);
        n_total++; if (match_count !== 2'd1) $display("FAIL gap_cnt: got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cur = "reset_mid";
        overlap = 1'b1;
        load(4'b1011);
        send_bits(16'b101, 3, 16'b000);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        send_bits(16'b1, 1, 16'b0);
        n_total++; if (armed !== 1'b0) $display("FAIL rmid_armed: got %b want 0", armed); else n_pass++;
        n_total++; if (match_count !== 2'd0) $display("FAIL rmid_cnt0: got %0d want 0", match_count); else n_pass++;
        load(4'b1011);
        send_bits(16'b1011, 4, 16'b0001);
        n_total++; if (match_count !== 2'd1) $display("FAIL rmid_cnt1: got %0d want 1", match_count); else n_pass++;
    endtask

    task automatic test_load_discard();
        cur = "load_discard";
        overlap = 1'b1;
        // Loaded sample would otherwise complete 1011 on the third bit below.
        pat_load = 1'b1; pat_in = 4'b1011; clr_cnt = 1'b1; ena = 1'b1; din = 1'b1;
        tick(1'b0);
        pat_load = 1'b0; clr_cnt = 1'b0;
        send_bits(16'b011, 3, 16'b000);
        pat_load = 1'b1; ena = 1'b1; din = 1'b1;
        tick(1'b0);
        pat_load = 1'b0;
        send_bits(16'b1011, 4, 16'b0001);
        n_total++; if (match_count !== 2'd1) $display("FAIL disc_cnt: got %0d want 1", match_count); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; din = 1'b0; pat_load = 1'b0;
        pat_in = '0; overlap = 1'b1; clr_cnt = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_saturate();
        test_clr_priority();
        test_ena_gap();
        test_reset_mid();
        test_load_discard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match counter width, legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ena  input  1  sample enable; din is sampled only when ena=1.
REQ-006 SHALL have port din  input  1  serial data bit.
REQ-007 SHALL have port pat_load  input  1  loads pat_in as the target pattern and arms the detector.
REQ-008 SHALL have port pat_in  input  PAT_W  target pattern; MSB is matched against the oldest bit.
REQ-009 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-010 SHALL have port clr_cnt  input  1  synchronous clear of match_count.
REQ-011 SHALL have port match  output  1  registered one-cycle pulse per detected pattern.
REQ-012 SHALL have port match_count  output  CNT_W  saturating count of matches.
REQ-013 SHALL have port cnt_sat  output  1  high while match_count equals all-ones.
REQ-014 SHALL have port armed  output  1  high in FILL or RUN.

Function
REQ-015 SHALL implement states UNARMED, FILL and RUN.
REQ-016 SHALL ignore din in UNARMED and hold match=0 there.
REQ-017 SHALL, on pat_load=1 in any state, store pat_in, clear history and fill count, and enter FILL; a sample on the same cycle is discarded.
REQ-018 SHALL, on each ena=1 cycle in FILL or RUN, shift din into history at the LSB: hist_next = {hist[PAT_W-2:0], din}.
REQ-019 SHALL, in FILL, increment the fill count per sample and enter RUN when PAT_W valid bits are held, including the current sample.
REQ-020 SHALL compare hist_next with the stored pattern only when PAT_W valid bits are held, and on equality set match=1 for exactly the next cycle (latency 1 clock from the sampling edge).
REQ-021 SHALL, with overlap=1, keep the history after a match, so bits may be shared between matches.
REQ-022 SHALL, with overlap=0, clear the history and fill count after a match and return to FILL.
REQ-023 SHALL, when ena=0, hold history, state and fill count, and drive match=0 on the next cycle.
REQ-024 SHALL increment match_count by 1 per match and hold it at all-ones once saturated, with no wrap.
REQ-025 SHALL give clr_cnt priority over a same-cycle match: match_count becomes 0 while the match pulse is still produced.
REQ-026 SHALL apply priority rst > pat_load > sample/compare.
REQ-027 SHALL drive cnt_sat and armed combinationally from registered state.

Reset
REQ-028 SHALL, while rst=1 on a clock edge, set state=UNARMED, stored pattern=0, history=0, fill count=0, match=0, match_count=0, cnt_sat=0 and armed=0.
REQ-029 SHALL, on a reset asserted mid-stream, discard all partial history and require a new pat_load before any further detection.

Verification
REQ-030 Bench SHALL check: PAT_W=4, pat_load with pat_in=1011, overlap=1, stream 1,0,1,1,0,1,1 with ena=1 -> match pulses one cycle after the 4th and 7th samples, match_count=2.
REQ-031 Bench SHALL check: the same stream with overlap=0 -> a single match after the 4th sample, match_count=1; the stream 10111011 -> match_count=2.
REQ-032 Bench SHALL check: CNT_W=2 with 5 matches -> match_count stays at 3, cnt_sat=1; then clr_cnt=1 -> match_count=0, cnt_sat=0.
REQ-033 Bench SHALL check: stream 101 followed by ena=0 for 3 cycles, then 1 -> exactly one match, and none during the idle cycles.
REQ-034 Bench SHALL check: rst=1 after the 3 bits 101, then 1 with no pat_load -> match=0, armed=0; after pat_load and 1011 -> match_count=1.
REQ-035 Bench SHALL check: pat_load while ena=1 with din=1 -> that sample is discarded, and 4 further samples are required before the first possible match.
